// File: rtl/shift_pkg.sv
// Shared shifter definitions: op encodings, datapath widths and the request payload struct.
package shift_pkg;
  localparam int SH_DATA_W = 32;
  localparam int SH_AMT_W  = 5;

  localparam logic [1:0] SH_SHL = 2'b00;
  localparam logic [1:0] SH_SHR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef struct packed {
    logic [SH_DATA_W-1:0] data;
    logic [1:0]           op;
    logic [SH_AMT_W-1:0]  amt;
  } sh_req_t;
endpackage

// File: rtl/shift_rr_arb.sv
// Request arbiter for shift_arbiter. Round-robin with a pointer register when
// SHIFT_ARB_ROUND_ROBIN_EN is defined, otherwise fixed lowest-index priority.
module shift_rr_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
`ifdef SHIFT_ARB_ROUND_ROBIN_EN
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
`endif
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx
);
`ifdef SHIFT_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] ptr;
  int              idx;
  logic            found;

  // Search starts at the pointer and wraps back to index 0.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
`else
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[k]) begin
        found   = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = ID_W'(k);
      end
    end
  end
`endif
endmodule

// File: rtl/shifter32.sv
// Shared combinational 32-bit barrel shifter: SHL, SHR (logical), ASR and ROR by 0..31.
module shifter32
  import shift_pkg::*;
(
  input  logic [31:0] in,
  input  logic [1:0]  op,
  input  logic [4:0]  s,
  output logic [31:0] out
);
  always_comb begin
    out = in;
    unique case (op)
      SH_SHL:  out = in << s;
      SH_SHR:  out = in >> s;
      SH_ASR:  out = $unsigned($signed(in) >>> s);
      default: out = (in >> s) | (in << (6'd32 - {1'b0, s}));
    endcase
  end
endmodule

// File: rtl/shift_arbiter.sv
// Shares one barrel shifter among N_REQ requesters through a two-stage operand/result pipeline.
// Arbitration policy selected by SHIFT_ARB_ROUND_ROBIN_EN (round-robin) or fixed priority when undefined.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [32*N_REQ-1:0]    req_data,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [5*N_REQ-1:0]     req_amt,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [SH_DATA_W-1:0]   resp_data,
  output logic [ID_W-1:0]        resp_id
);
  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // the sender holds valid and payload stable until then, and valid never waits on ready.
  logic                 s1_valid;
  sh_req_t              s1_req;
  sh_req_t              req_sel;
  logic [ID_W-1:0]      s1_id;
  logic [ID_W-1:0]      gnt_idx;
  logic [N_REQ-1:0]     gnt;
  logic                 s2_free;
  logic                 s1_open;
  logic                 take;
  logic [SH_DATA_W-1:0] sh_out;

  assign s2_free   = !resp_valid || resp_ready;
  assign s1_open   = !s1_valid || s2_free;
  assign req_ready = (s1_open && !reset) ? gnt : '0;
  assign take      = |req_ready;

  always_comb begin
    req_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        req_sel.data = req_data[SH_DATA_W*i +: SH_DATA_W];
        req_sel.op   = req_op[2*i +: 2];
        req_sel.amt  = req_amt[SH_AMT_W*i +: SH_AMT_W];
      end
    end
  end

  shift_rr_arb #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
`ifdef SHIFT_ARB_ROUND_ROBIN_EN
    .clk     (clk),
    .reset   (reset),
    .adv     (take),
`endif
    .req     (req_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  shifter32 u_shift (
    .in  (s1_req.data),
    .op  (s1_req.op),
    .s   (s1_req.amt),
    .out (sh_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_req     <= '0;
      s1_id      <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
    end else begin
      if (s2_free) begin
        resp_valid <= s1_valid;
        if (s1_valid) begin
          resp_data <= sh_out;
          resp_id   <= s1_id;
        end
      end
      // S1 reloads whenever it empties or hands its operand to S2 on this edge.
      if (s1_open) begin
        s1_valid <= take;
        if (take) begin
          s1_req <= req_sel;
          s1_id  <= gnt_idx;
        end
      end
    end
  end
endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model (bitwise shift reference, capacity-2 pipeline queue).
module tb_shift_arbiter;
`ifdef SHIFT_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_data;
  logic [7:0]   req_op;
  logic [19:0]  req_amt;
  logic         resp_valid;
  logic         resp_ready;
  logic [31:0]  resp_data;
  logic [1:0]   resp_id;

  logic [31:0]  pd[4];
  logic [1:0]   po[4];
  logic [4:0]   pa[4];

  int n_chk = 0;
  int n_pass = 0;

  logic [33:0]  exp_q[$];
  int           acc_q[$];
  int           m_ptr = 0;
  int           cyc = 0;
  logic [3:0]   acc_vec = '0;

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    req_op   = '0;
    req_amt  = '0;
    for (int i = 0; i < 4; i++) begin
      req_data[32*i +: 32] = pd[i];
      req_op[2*i +: 2]     = po[i];
      req_amt[5*i +: 5]    = pa[i];
    end
  end

  shift_arbiter #(.N_REQ(4), .ID_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_op     (req_op),
    .req_amt    (req_amt),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
  );

  // Bit-by-bit definition of each shift op.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [1:0] op, input int amt);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      case (op)
        2'b00:   r[i] = (i >= amt) ? d[i-amt] : 1'b0;
        2'b01:   r[i] = (i + amt < 32) ? d[i+amt] : 1'b0;
        2'b10:   r[i] = (i + amt < 32) ? d[i+amt] : d[31];
        default: r[i] = d[(i+amt)%32];
      endcase
    end
    return r;
  endfunction

  function automatic int ref_pick(input logic [3:0] v);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = RR ? (m_ptr + k) % 4 : k;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Two results fit in flight; a full pipeline only accepts when the head is being consumed.
  function automatic logic [3:0] exp_ready();
    int p;
    if (reset) return 4'b0000;
    p = ref_pick(req_valid);
    if (p < 0) return 4'b0000;
    if (exp_q.size() >= 2 && !resp_ready) return 4'b0000;
    return 4'(1 << p);
  endfunction

  function automatic logic exp_rvalid();
    return (exp_q.size() > 0) && (acc_q[0] < cyc);
  endfunction

  task automatic tick();
    logic [3:0] r;
    logic       rv;
    int         p;
    r = exp_ready();
    rv = exp_rvalid();
    acc_vec = '0;
    if (reset) begin
      exp_q.delete();
      acc_q.delete();
      m_ptr = 0;
    end else begin
      if (rv && resp_ready) begin
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
      end
      p = ref_pick(req_valid);
      if (r != 4'b0000) begin
        exp_q.push_back({2'(p), ref_shift(pd[p], po[p], int'(pa[p]))});
        acc_q.push_back(cyc + 1);
        acc_vec[p] = 1'b1;
        m_ptr = (p + 1) % 4;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    resp_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drain(input int n);
    req_valid = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '0;
    resp_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    n_chk++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready got=%b exp=0000", req_ready); else n_pass++;
    n_chk++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); else n_pass++;
    n_chk++; if (resp_data !== 32'h0) $display("FAIL reset_resp_data got=%h exp=0", resp_data); else n_pass++;
    n_chk++; if (resp_id !== 2'd0) $display("FAIL reset_resp_id got=%0d exp=0", resp_id); else n_pass++;
    reset = 1'b0;
    resp_ready = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [31:0] td[8];
    logic [1:0]  top[8];
    logic [4:0]  tam[8];
    logic [31:0] tex[8];
    td  = '{32'h00000001, 32'hF0000000, 32'h80000000, 32'h80000001,
            32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
    top = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
    tam = '{5'd31, 5'd28, 5'd4, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0};
    tex = '{32'h80000000, 32'h0000000F, 32'hF8000000, 32'hC0000000,
            32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
    resp_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      pd[0] = td[t]; po[0] = top[t]; pa[0] = tam[t];
      req_valid = 4'b0001;
      @(negedge clk);
      n_chk++; if (req_ready !== 4'b0001) $display("FAIL single%0d_accept got=%b exp=0001", t, req_ready); else n_pass++;
      tick();
      req_valid = '0;
      @(negedge clk);
      n_chk++; if (resp_valid !== 1'b0) $display("FAIL single%0d_early got=%b exp=0", t, resp_valid); else n_pass++;
      tick();
      @(negedge clk);
      n_chk++; if (resp_valid !== 1'b1) $display("FAIL single%0d_valid got=%b exp=1", t, resp_valid); else n_pass++;
      n_chk++; if (resp_data !== tex[t]) $display("FAIL single%0d_data got=%h exp=%h", t, resp_data, tex[t]); else n_pass++;
      n_chk++; if (resp_id !== 2'd0) $display("FAIL single%0d_id got=%0d exp=0", t, resp_id); else n_pass++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] er;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pd[i] = 32'h0000_0011 << (i * 4); po[i] = 2'(i); pa[i] = 5'(i + 1);
    end
    req_valid = 4'b1111;
    resp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      er = RR ? 4'(1 << (c % 4)) : 4'b0001;
      n_chk++; if (req_ready !== er) $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, req_ready, er); else n_pass++;
      n_chk++; if (resp_valid !== (c >= 2)) $display("FAIL b2b_valid c=%0d got=%b exp=%b", c, resp_valid, c >= 2); else n_pass++;
      if (exp_rvalid()) begin
        n_chk++;
        if (resp_id !== (RR ? 2'((c - 2) % 4) : 2'd0) || {resp_id, resp_data} !== exp_q[0])
          $display("FAIL b2b_resp c=%0d got=%0d/%h exp=%0d/%h", c, resp_id, resp_data, exp_q[0][33:32], exp_q[0][31:0]);
        else n_pass++;
      end
      tick();
    end
    drain(4);
  endtask

  task automatic test_stall();
    int          n_acc;
    int          n_rsp;
    logic [3:0]  rsp_mask;
    logic [33:0] held;
    logic        have;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pd[i] = 32'h1234_5678 ^ (32'h1111_1111 * i); po[i] = 2'b11; pa[i] = 5'(4 * i + 3);
    end
    n_acc = 0; n_rsp = 0; rsp_mask = '0; have = 1'b0; held = '0;
    req_valid = 4'b1111;
    resp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_chk++; if (req_ready !== exp_ready()) $display("FAIL stall_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready()); else n_pass++;
      if (req_ready != 4'b0000) n_acc++;
      if (resp_valid === 1'b1) begin
        if (!have) begin
          held = {resp_id, resp_data};
          have = 1'b1;
        end else begin
          n_chk++; if ({resp_id, resp_data} !== held) $display("FAIL stall_hold c=%0d got=%h exp=%h", c, {resp_id, resp_data}, held); else n_pass++;
        end
      end
      tick();
    end
    n_chk++; if (n_acc !== 2) $display("FAIL stall_accepts got=%0d exp=2", n_acc); else n_pass++;
    req_valid = '0;
    resp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_chk++; if (resp_valid !== exp_rvalid()) $display("FAIL release_valid c=%0d got=%b exp=%b", c, resp_valid, exp_rvalid()); else n_pass++;
      if (resp_valid === 1'b1) begin
        n_rsp++;
        rsp_mask[c] = 1'b1;
        if (exp_rvalid()) begin
          n_chk++; if ({resp_id, resp_data} !== exp_q[0]) $display("FAIL release_data c=%0d got=%h exp=%h", c, {resp_id, resp_data}, exp_q[0]); else n_pass++;
        end
      end
      tick();
    end
    n_chk++; if (n_rsp !== 2) $display("FAIL release_count got=%0d exp=2", n_rsp); else n_pass++;
    n_chk++; if (rsp_mask !== 4'b0011) $display("FAIL release_order got=%b exp=0011", rsp_mask); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    pd[2] = 32'hDEAD_BEEF; po[2] = 2'b01; pa[2] = 5'd8;
    req_valid = 4'b0100;
    resp_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (req_ready !== 4'b0100) $display("FAIL midrst_accept got=%b exp=0100", req_ready); else n_pass++;
    tick();
    req_valid = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++; if (resp_valid !== 1'b0) $display("FAIL midrst_noresp c=%0d got=%b exp=0", c, resp_valid); else n_pass++;
      tick();
    end
    req_valid = 4'b1111;
    @(negedge clk);
    n_chk++; if (req_ready !== 4'b0001) $display("FAIL midrst_ptr got=%b exp=0001", req_ready); else n_pass++;
    tick();
    drain(4);
  endtask

  task automatic test_rr_wrap();
    logic [3:0] e1;
    do_reset();
    pd[1] = 32'h0F0F_0F0F; po[1] = 2'b00; pa[1] = 5'd4;
    pd[3] = 32'h8000_00F0; po[3] = 2'b10; pa[3] = 5'd12;
    req_valid = 4'b0010;
    resp_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (req_ready !== 4'b0010) $display("FAIL wrap_setup got=%b exp=0010", req_ready); else n_pass++;
    tick();
    req_valid = 4'b1010;
    e1 = RR ? 4'b1000 : 4'b0010;
    @(negedge clk);
    n_chk++; if (req_ready !== e1) $display("FAIL wrap_first got=%b exp=%b", req_ready, e1); else n_pass++;
    tick();
    @(negedge clk);
    n_chk++; if (req_ready !== 4'b0010) $display("FAIL wrap_second got=%b exp=0010", req_ready); else n_pass++;
    n_chk++; if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_data !== 32'hF0F0_F0F0)
      $display("FAIL wrap_resp got=%b/%0d/%h exp=1/1/f0f0f0f0", resp_valid, resp_id, resp_data); else n_pass++;
    tick();
    drain(4);
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i] || acc_vec[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          pd[i] = $urandom;
          po[i] = 2'($urandom_range(0, 3));
          pa[i] = ($urandom_range(0, 3) == 0) ? 5'(31 * $urandom_range(0, 1)) : 5'($urandom_range(0, 31));
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n_chk++; if (req_ready !== exp_ready()) $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready()); else n_pass++;
      n_chk++; if (resp_valid !== exp_rvalid()) $display("FAIL rand_valid c=%0d got=%b exp=%b", c, resp_valid, exp_rvalid()); else n_pass++;
      if (exp_rvalid()) begin
        n_chk++; if ({resp_id, resp_data} !== exp_q[0]) $display("FAIL rand_data c=%0d got=%0d/%h exp=%0d/%h", c, resp_id, resp_data, exp_q[0][33:32], exp_q[0][31:0]); else n_pass++;
      end
      tick();
    end
    drain(4);
    n_chk++; if (exp_q.size() != 0) $display("FAIL rand_leftover got=%0d exp=0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pd[i] = '0; po[i] = '0; pa[i] = '0;
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_rr_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
